// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
//   Shared definitions for the encoder control blocks.
//   - enc_state_e   : scheduler FSM state encoding (2-bit)
//   - ISSUE_GAP_MIN : smallest legal spacing between symbol accepts
//   - GAP_CNT_W     : width of the issue-gap counter (holds ISSUE_GAP-1 <= 14)
// -----------------------------------------------------------------------------
package encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } enc_state_e;

    localparam int ISSUE_GAP_MIN = 2;
    localparam int GAP_CNT_W     = 4;

endpackage

// File: rtl/encoder_issue_gap_counter.sv
// -----------------------------------------------------------------------------
// encoder_issue_gap_counter
//   Down-counter enforcing the minimum spacing between symbol accepts.
//   Loaded with ISSUE_GAP-1 on an accept, decrements to 0 and holds there.
//
//   Ports
//     general_clk : clock, rising edge
//     reset       : synchronous, active-high; counter -> 0
//     clear_i     : force counter to 0 (frame start)
//     load_i      : load load_val_i (symbol accepted)
//     load_val_i  : reload value
//     zero_o      : counter is 0, a new accept is allowed
// -----------------------------------------------------------------------------
module encoder_issue_gap_counter
    import encoder_pkg::*;
(
    input  logic                 general_clk,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [GAP_CNT_W-1:0] load_val_i,
    output logic                 zero_o
);

    logic [GAP_CNT_W-1:0] cnt_q;
    logic [GAP_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - GAP_CNT_W'(1);
        end
    end

    always_ff @(posedge general_clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/encoder_symbol_scheduler.sv
// -----------------------------------------------------------------------------
// encoder_symbol_scheduler
//   Control-only scheduler for the three-stage encoder pipeline. Accepts
//   upstream symbols no closer than ISSUE_GAP cycles apart, generates the
//   per-stage load enables and signals frame completion. No data passes
//   through this block.
//
//   Parameters
//     ISSUE_GAP : minimum cycles between accepts (2..15)
//     CNT_WIDTH : width of sym_count
//
//   Ports
//     general_clk : clock, rising edge
//     reset       : synchronous, active-high
//     frame_start : start a frame (IDLE only)
//     sym_valid   : upstream symbol present
//     sym_last    : presented symbol is the frame's last
//     sym_ready   : symbol accepted this cycle when sym_valid is high
//     enc_init    : one-cycle pulse loading encoder final-register init values
//     en_1_2      : stage 1->2 load enable (the accept itself)
//     en_2_3      : stage 2->3 load enable (accept + 1)
//     en_final    : final-register load enable (accept + 2)
//     frame_done  : pulse when the last symbol lands in the final registers
//     busy        : FSM not in IDLE
//     sym_count   : symbols accepted in the current frame (wraps)
// -----------------------------------------------------------------------------
module encoder_symbol_scheduler
    import encoder_pkg::*;
#(
    parameter int ISSUE_GAP = 2,
    parameter int CNT_WIDTH = 16
)(
    input  logic                 general_clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 sym_valid,
    input  logic                 sym_last,
    output logic                 sym_ready,
    output logic                 enc_init,
    output logic                 en_1_2,
    output logic                 en_2_3,
    output logic                 en_final,
    output logic                 frame_done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] sym_count
);

    // Out-of-range gaps are clamped to the minimum so the hazard rule holds.
    localparam logic [GAP_CNT_W-1:0] GAP_RELOAD = GAP_CNT_W'(
        (ISSUE_GAP < ISSUE_GAP_MIN) ? (ISSUE_GAP_MIN - 1) : (ISSUE_GAP - 1));

    enc_state_e           state_q,     state_d;
    logic [1:0]           vld_q,       vld_d;
    logic [1:0]           last_q,      last_d;
    logic [CNT_WIDTH-1:0] sym_count_q, sym_count_d;

    logic gap_zero;
    logic in_run;
    logic accept;
    logic last_landed;

    assign in_run = (state_q == ST_RUN);

    // Outputs are masked by reset so an in-flight enable never escapes in
    // the reset cycle itself.
    assign accept      = in_run && gap_zero && sym_valid && !reset;
    assign last_landed = vld_q[1] && last_q[1];

    encoder_issue_gap_counter u_gap (
        .general_clk (general_clk),
        .reset       (reset),
        .clear_i     (state_q == ST_INIT),
        .load_i      (accept),
        .load_val_i  (GAP_RELOAD),
        .zero_o      (gap_zero)
    );

    always_comb begin
        state_d     = state_q;
        sym_count_d = sym_count_q;
        // Two-flop valid shift register with a parallel sym_last tag so that
        // frame_done lines up with the last symbol's en_final.
        vld_d       = {vld_q[0], accept};
        last_d      = {last_q[0], accept && sym_last};

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                sym_count_d = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    sym_count_d = sym_count_q + CNT_WIDTH'(1);
                    if (sym_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (last_landed) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge general_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vld_q       <= '0;
            last_q      <= '0;
            sym_count_q <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign sym_ready  = in_run && gap_zero && !reset;
    assign enc_init   = (state_q == ST_INIT) && !reset;
    assign en_1_2     = accept;
    assign en_2_3     = vld_q[0] && !reset;
    assign en_final   = vld_q[1] && !reset;
    assign frame_done = last_landed && !reset;
    assign busy       = (state_q != ST_IDLE) && !reset;
    assign sym_count  = reset ? '0 : sym_count_q;

endmodule

// File: tb/tb_encoder_symbol_scheduler.sv
// -----------------------------------------------------------------------------
// tb_encoder_symbol_scheduler
//   Directed bench for encoder_symbol_scheduler. Two instances:
//     u_a : ISSUE_GAP=2, CNT_WIDTH=16
//     u_b : ISSUE_GAP=3, CNT_WIDTH=4
//   Inputs change 1 ns after the rising edge; outputs are checked on the
//   falling edge. Control outputs are packed as
//   {sym_ready, enc_init, en_1_2, en_2_3, en_final, frame_done, busy}.
// -----------------------------------------------------------------------------
module tb_encoder_symbol_scheduler;

    logic        general_clk = 1'b0;
    logic        reset       = 1'b1;

    logic        fs_a = 1'b0, sv_a = 1'b0, sl_a = 1'b0;
    logic        a_rdy, a_init, a_e12, a_e23, a_efin, a_fd, a_busy;
    logic [15:0] a_cnt;

    logic        fs_b = 1'b0, sv_b = 1'b0, sl_b = 1'b0;
    logic        b_rdy, b_init, b_e12, b_e23, b_efin, b_fd, b_busy;
    logic [3:0]  b_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 general_clk = ~general_clk;

    encoder_symbol_scheduler #(.ISSUE_GAP(2), .CNT_WIDTH(16)) u_a (
        .general_clk (general_clk),
        .reset       (reset),
        .frame_start (fs_a),
        .sym_valid   (sv_a),
        .sym_last    (sl_a),
        .sym_ready   (a_rdy),
        .enc_init    (a_init),
        .en_1_2      (a_e12),
        .en_2_3      (a_e23),
        .en_final    (a_efin),
        .frame_done  (a_fd),
        .busy        (a_busy),
        .sym_count   (a_cnt)
    );

    encoder_symbol_scheduler #(.ISSUE_GAP(3), .CNT_WIDTH(4)) u_b (
        .general_clk (general_clk),
        .reset       (reset),
        .frame_start (fs_b),
        .sym_valid   (sv_b),
        .sym_last    (sl_b),
        .sym_ready   (b_rdy),
        .enc_init    (b_init),
        .en_1_2      (b_e12),
        .en_2_3      (b_e23),
        .en_final    (b_efin),
        .frame_done  (b_fd),
        .busy        (b_busy),
        .sym_count   (b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic edge_drive();
        @(posedge general_clk);
        #1;
    endtask

    function automatic logic [6:0] pack(input logic rdy, input logic init, input logic e12,
                                        input logic e23, input logic efin, input logic fd,
                                        input logic bsy);
        return {rdy, init, e12, e23, efin, fd, bsy};
    endfunction

    // u_b stimulus: accepts at 3, 7, 11, ... , 67 (17 symbols)
    function automatic logic b_acc(input int k);
        return (k >= 3) && (k <= 67) && (((k - 3) % 4) == 0);
    endfunction

    initial begin
        logic [6:0] exp_ctl;
        logic [31:0] exp_cnt;
        int last_acc;

        // ---------------- frame of 4 symbols, ISSUE_GAP=2 ----------------
        for (int c = 0; c <= 14; c++) begin
            edge_drive();
            reset = (c <= 1);
            fs_a  = (c == 2);
            sv_a  = (c >= 2) && (c <= 10);
            sl_a  = (c >= 9) && (c <= 10);
            @(negedge general_clk);
            if (c >= 1) begin
                exp_ctl = pack((c == 4) || (c == 6) || (c == 8) || (c == 10),
                               (c == 3),
                               (c == 4) || (c == 6) || (c == 8) || (c == 10),
                               (c == 5) || (c == 7) || (c == 9) || (c == 11),
                               (c == 6) || (c == 8) || (c == 10) || (c == 12),
                               (c == 12),
                               (c >= 3) && (c <= 12));
                exp_cnt = (c <= 4) ? 0 : (c <= 6) ? 1 : (c <= 8) ? 2 : (c <= 10) ? 3 : 4;
                check_eq($sformatf("t1_ctl_c%0d", c),
                         32'(pack(a_rdy, a_init, a_e12, a_e23, a_efin, a_fd, a_busy)),
                         32'(exp_ctl));
                check_eq($sformatf("t1_cnt_c%0d", c), 32'(a_cnt), exp_cnt);
            end
            if (c == 1) begin
                check_eq("t1_reset_b_ctl",
                         32'(pack(b_rdy, b_init, b_e12, b_e23, b_efin, b_fd, b_busy)), 0);
                check_eq("t1_reset_b_cnt", 32'(b_cnt), 0);
            end
        end

        // ------- single-symbol frame, frame_start/sym_valid during FLUSH -------
        for (int k = 0; k <= 8; k++) begin
            edge_drive();
            fs_a = (k == 0) || (k == 3) || (k == 4);
            sv_a = (k == 0) || (k == 2) || (k == 3) || (k == 4);
            sl_a = sv_a;
            @(negedge general_clk);
            exp_ctl = pack(k == 2, k == 1, k == 2, k == 3, k == 4, k == 4,
                           (k >= 1) && (k <= 4));
            exp_cnt = (k <= 1) ? 4 : (k == 2) ? 0 : 1;
            check_eq($sformatf("t2_ctl_k%0d", k),
                     32'(pack(a_rdy, a_init, a_e12, a_e23, a_efin, a_fd, a_busy)),
                     32'(exp_ctl));
            check_eq($sformatf("t2_cnt_k%0d", k), 32'(a_cnt), exp_cnt);
        end

        // ---------------- reset one cycle after an accept ----------------
        for (int k = 0; k <= 6; k++) begin
            edge_drive();
            fs_a  = (k == 0);
            sv_a  = (k <= 5);
            sl_a  = 1'b0;
            reset = (k == 3);
            @(negedge general_clk);
            exp_ctl = pack(k == 2, k == 1, k == 2, 1'b0, 1'b0, 1'b0, (k == 1) || (k == 2));
            exp_cnt = (k <= 1) ? 1 : 0;
            check_eq($sformatf("t3_ctl_k%0d", k),
                     32'(pack(a_rdy, a_init, a_e12, a_e23, a_efin, a_fd, a_busy)),
                     32'(exp_ctl));
            check_eq($sformatf("t3_cnt_k%0d", k), 32'(a_cnt), exp_cnt);
        end
        sv_a = 1'b0;

        // ------ ISSUE_GAP=3, toggling sym_valid, 17 symbols, 4-bit count ------
        last_acc = -1;
        for (int k = 0; k <= 72; k++) begin
            edge_drive();
            fs_b = (k == 0);
            sv_b = (k % 2) == 1;
            sl_b = (k >= 64);
            @(negedge general_clk);
            exp_ctl = pack((k >= 2) && (k <= 67) && ((((k - 2) % 4) == 0) || (((k - 3) % 4) == 0)),
                           (k == 1),
                           b_acc(k),
                           b_acc(k - 1),
                           b_acc(k - 2),
                           (k == 69),
                           (k >= 1) && (k <= 69));
            exp_cnt = (k <= 3) ? 0 : 32'(((k / 4) > 17 ? 17 : (k / 4)) % 16);
            check_eq($sformatf("t4_ctl_k%0d", k),
                     32'(pack(b_rdy, b_init, b_e12, b_e23, b_efin, b_fd, b_busy)),
                     32'(exp_ctl));
            check_eq($sformatf("t4_cnt_k%0d", k), 32'(b_cnt), exp_cnt);
            if (b_e12) begin
                if (last_acc >= 0) begin
                    check_eq($sformatf("t4_spacing_k%0d", k), 32'((k - last_acc) >= 3), 1);
                end
                last_acc = k;
            end
        end
        sv_b = 1'b0;
        sl_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
